// File: rtl/fnd_pkg.sv
// ---------------------------------------------------------------------------
// fnd_pkg
//   Shared definitions for the 4-digit FND scan controller.
//   - Frame geometry: DIGITS, IDX_W, NIB_W and the derived FRAME_W.
//   - Scan state encoding.
//   - div_cycles(): clock cycles spent on each digit slot.
//   - lead_zero(): decides whether a digit is a leading zero that may be
//     blanked. It is only used when FND_LZB_EN is defined.
// ---------------------------------------------------------------------------
package fnd_pkg;

  localparam int DIGITS  = 4;
  localparam int IDX_W   = 2;
  localparam int NIB_W   = 4;
  localparam int FRAME_W = DIGITS * NIB_W;

  // IDLE  : scanning stopped, every digit dark.
  // BLANK : anti-ghosting guard at the start of each digit slot.
  // SHOW  : the selected digit is lit.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } fnd_state_t;

  // Number of clock cycles in one digit slot.
  function automatic int div_cycles(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction

  // A digit is a leading zero when it and every more-significant digit are
  // zero. The rightmost digit is never treated as a leading zero, so a frame
  // of all zeros still shows a single "0".
  function automatic logic lead_zero(input logic [FRAME_W-1:0] frame,
                                     input logic [IDX_W-1:0]   idx);
    logic dark;
    case (idx)
      2'd3:    dark = (frame[15:12] == 4'h0);
      2'd2:    dark = (frame[15:8]  == 8'h00);
      2'd1:    dark = (frame[15:4]  == 12'h000);
      default: dark = 1'b0;
    endcase
    return dark;
  endfunction

endpackage

// File: rtl/fnd_prescaler.sv
// ---------------------------------------------------------------------------
// fnd_prescaler
//   Divides the system clock down to the per-digit slot rate. The count runs
//   0..DIV-1 while i_run is high and is cleared whenever i_run is low. This
//   way every slot starts from a count of zero, including the first slot
//   after an enable.
//
// Ports
//   i_clk      in  1  clock
//   i_reset_n  in  1  synchronous, active-low reset
//   i_run      in  1  1 = count, 0 = clear and hold at zero
//   o_tick     out 1  high for one cycle while the count sits at DIV-1
// ---------------------------------------------------------------------------
module fnd_prescaler #(
  parameter int DIV = 10
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_run,
  output logic o_tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Slot counter. It wraps at DIV-1 and is cleared whenever the scan is
  // not running.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt <= '0;
    end else if (!i_run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Gate the tick with i_run. A stop that lands on the last count must not
  // also advance the digit index.
  assign o_tick = i_run && (cnt == LAST);

endmodule

// File: rtl/fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// fnd_scan_ctrl
//   Time-multiplexed scan controller for a 4-digit common-anode FND. It feeds
//   a 2-to-4 digit-select decoder and a BCD-to-segment decoder.
//
//   Each digit slot lasts DIV = CLK_HZ/SCAN_HZ cycles. The slot starts with
//   GUARD_CYCLES blanked cycles, which stop the previous digit's segments
//   from ghosting onto the new digit. The rest of the slot shows the digit.
//
//   New frames go into a shadow register. They are copied to the display
//   register only when the index wraps 3->0, so a frame is never torn
//   across digits.
//
//   Nibbles 0xA-0xF pass through untouched; the segment decoder owns their
//   glyphs.
//
// Parameters
//   CLK_HZ        input clock frequency
//   SCAN_HZ       per-digit slot rate. Requires DIV >= GUARD_CYCLES+2.
//   GUARD_CYCLES  blank cycles at the start of each digit slot (>= 1)
//
// Ports
//   i_clk        in   1   clock
//   i_reset_n    in   1   synchronous, active-low reset
//   i_enable     in   1   1 = scanning, 0 = display off
//   i_valid      in   1   single-cycle strobe that captures i_bcd
//   i_bcd        in   16  {d3,d2,d1,d0} BCD nibbles, d0 = rightmost digit
//   o_digit_sel  out  2   digit index to the select decoder
//   o_blank      out  1   select-decoder enable, 1 = all digits off
//   o_bcd        out  4   nibble of the selected digit
//   o_frame      out  1   one-cycle pulse when the index wraps 3->0
//
// Build option
//   FND_LZB_EN   When defined, enables leading-zero blanking. While in SHOW,
//                digits 3..1 stay dark if they and all higher digits are
//                zero. Digit 0 is always shown. When undefined, all four
//                digits are shown.
// ---------------------------------------------------------------------------
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1_000,
  parameter int GUARD_CYCLES = 100
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_enable,
  input  logic               i_valid,
  input  logic [FRAME_W-1:0] i_bcd,
  output logic [IDX_W-1:0]   o_digit_sel,
  output logic               o_blank,
  output logic [NIB_W-1:0]   o_bcd,
  output logic               o_frame
);

  localparam int DIV     = div_cycles(CLK_HZ, SCAN_HZ);
  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);

  fnd_state_t         state;
  fnd_state_t         state_next;
  logic [GUARD_W-1:0] guard;
  logic [GUARD_W-1:0] guard_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_next;
  logic [FRAME_W-1:0] shadow;
  logic [FRAME_W-1:0] display;
  logic [FRAME_W-1:0] display_next;
  logic               pending;
  logic               run;
  logic               tick;
  logic               wrap;
  logic               blank_next;
  logic [NIB_W-1:0]   bcd_next;

  // The prescaler counts only while the scan is active and stays enabled.
  // Dropping i_enable clears it on the same edge that enters IDLE, so it
  // already reads zero throughout IDLE.
  assign run = (state != IDLE) && i_enable;

  fnd_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_run     (run),
    .o_tick    (tick)
  );

  // State register. It also holds the guard counter and the digit index,
  // since both advance in lockstep with the state.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state <= IDLE;
      guard <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      guard <= guard_next;
      idx   <= idx_next;
    end
  end

  // Next-state logic.
  // - Disabling wins from any state.
  // - A slot tick always restarts the guard.
  // - Otherwise BLANK lasts until the guard counter reaches its last cycle.
  always_comb begin
    state_next = state;
    if (!i_enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = BLANK;
        BLANK: begin
          if (tick) begin
            state_next = BLANK;
          end else if (guard == GUARD_LAST) begin
            state_next = SHOW;
          end
        end
        SHOW: begin
          if (tick) begin
            state_next = BLANK;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Guard counter, digit index and frame commit.
  // - The guard counts only while BLANK continues within one slot. Any
  //   entry into BLANK sees zero.
  // - At the wrap, a strobe arriving on that very cycle is shown at once.
  //   Otherwise a pending shadow frame is committed.
  always_comb begin
    guard_next = '0;
    if ((state == BLANK) && (state_next == BLANK) && !tick) begin
      guard_next = guard + GUARD_W'(1);
    end

    idx_next = idx;
    if (tick) begin
      idx_next = idx + IDX_W'(1);
    end

    wrap = tick && (idx == IDX_W'(DIGITS - 1));

    display_next = display;
    if (wrap) begin
      if (i_valid) begin
        display_next = i_bcd;
      end else if (pending) begin
        display_next = shadow;
      end
    end
  end

  // Output decode.
  // - Decoded from the next-state values, so the registered outputs change
  //   on the same edge as the state.
  // - The nibble and the index switch together. This always happens on an
  //   edge that enters BLANK, so the change is hidden.
  always_comb begin
    bcd_next   = display_next[{idx_next, 2'b00} +: NIB_W];
    blank_next = (state_next != SHOW);
`ifdef FND_LZB_EN
    if (lead_zero(display_next, idx_next)) begin
      blank_next = 1'b1;
    end
`else
`endif
  end

  // Frame capture.
  // - Capture is accepted in every state, including IDLE.
  // - The last strobe before a wrap wins.
  // - Pending clears at the wrap whichever source fed the display.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      shadow  <= '0;
      pending <= 1'b0;
      display <= '0;
    end else begin
      if (i_valid) begin
        shadow <= i_bcd;
      end
      if (wrap) begin
        pending <= 1'b0;
      end else if (i_valid) begin
        pending <= 1'b1;
      end
      display <= display_next;
    end
  end

  // Registered outputs that feed the external decoders.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      o_blank <= 1'b1;
      o_bcd   <= '0;
      o_frame <= 1'b0;
    end else begin
      o_blank <= blank_next;
      o_bcd   <= bcd_next;
      o_frame <= wrap;
    end
  end

  assign o_digit_sel = idx;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fnd_scan_ctrl
//   Directed bench for fnd_scan_ctrl with DIV=10 and GUARD_CYCLES=2.
//   The driver pushes the expected outputs for every cycle it drives. A
//   separate monitor pops one entry per cycle and compares it with the DUT.
//   Expectations for leading-zero blanking follow FND_LZB_EN.
// ---------------------------------------------------------------------------
module tb_fnd_scan_ctrl;

  localparam int CLK_HZ  = 1000;
  localparam int SCAN_HZ = 100;
  localparam int GUARD   = 2;
  localparam int DIV     = 10;

`ifdef FND_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct packed {
    logic [1:0] sel;
    logic       blank;
    logic [3:0] bcd;
    logic       frame;
    logic [7:0] test_id;
  } exp_t;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable  = 1'b0;
  logic        valid   = 1'b0;
  logic [15:0] bcd_in  = 16'h0000;
  logic [1:0]  digit_sel;
  logic        blank;
  logic [3:0]  bcd_out;
  logic        frame;

  exp_t exp_q[$];
  int   total  = 0;
  int   bad    = 0;
  int   cyc    = 0;
  bit   mon_on = 1'b0;

  fnd_scan_ctrl #(
    .CLK_HZ       (CLK_HZ),
    .SCAN_HZ      (SCAN_HZ),
    .GUARD_CYCLES (GUARD)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_enable    (enable),
    .i_valid     (valid),
    .i_bcd       (bcd_in),
    .o_digit_sel (digit_sel),
    .o_blank     (blank),
    .o_bcd       (bcd_out),
    .o_frame     (frame)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge. Queue the outputs the DUT
  // must show after the following rising edge.
  task automatic applyStimulus(input logic rst_n, input logic en, input logic vld,
                               input logic [15:0] bcd, input logic [1:0] esel,
                               input logic eblank, input logic [3:0] ebcd,
                               input logic eframe, input int tid);
    exp_t e;
    @(negedge clk);
    reset_n = rst_n;
    enable  = en;
    valid   = vld;
    bcd_in  = bcd;
    e.sel     = esel;
    e.blank   = eblank;
    e.bcd     = ebcd;
    e.frame   = eframe;
    e.test_id = 8'(tid);
    exp_q.push_back(e);
    mon_on = 1'b1;
  endtask

  // One digit slot, or its first n cycles, with scanning enabled.
  // - The first GUARD cycles are blank; the rest are shown unless dark.
  // - o_frame is expected only on the first cycle, and only when frm is set.
  // - An optional capture strobe is placed at cycle valid_at.
  task automatic run_slot(input logic [1:0] sel, input logic [3:0] nib, input logic frm,
                          input logic dark, input int valid_at, input logic [15:0] vbcd,
                          input int tid, input int n);
    for (int j = 0; j < n; j++) begin
      applyStimulus(1'b1, 1'b1, (j == valid_at), (j == valid_at) ? vbcd : 16'h0000,
                    sel, (j < GUARD) || dark, nib, frm && (j == 0), tid);
    end
  endtask

  // Compare the current outputs against the oldest queued expectation.
  task automatic checkOutput();
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("[TB] FAIL no_expect cycle%0d got sel=%0d blank=%0b bcd=%h frame=%0b, nothing queued",
               cyc, digit_sel, blank, bcd_out, frame);
    end else begin
      e = exp_q.pop_front();
      if ({digit_sel, blank, bcd_out, frame} !== {e.sel, e.blank, e.bcd, e.frame}) begin
        bad++;
        $display("[TB] FAIL t%0d_cycle%0d got sel=%0d blank=%0b bcd=%h frame=%0b want sel=%0d blank=%0b bcd=%h frame=%0b",
                 e.test_id, cyc, digit_sel, blank, bcd_out, frame, e.sel, e.blank, e.bcd, e.frame);
      end
    end
  endtask

  // Monitor: samples 2 time units after every rising edge while armed.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_on) begin
        cyc++;
        checkOutput();
      end
    end
  end

  initial begin
    $display("[TB] start, LZB=%0b", LZB);

    // Reset values.
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h0, 1'b0, 0);

    // 1: first enable. Blank guard, then digits step 0..3; frame pulses at the wrap.
    run_slot(2'd0, 4'h0, 1'b0, 1'b0, -1, 16'h0000, 1, DIV);
    run_slot(2'd1, 4'h0, 1'b0, LZB,  -1, 16'h0000, 1, DIV);
    run_slot(2'd2, 4'h0, 1'b0, LZB,  -1, 16'h0000, 1, DIV);
    run_slot(2'd3, 4'h0, 1'b0, LZB,  -1, 16'h0000, 1, DIV);
    run_slot(2'd0, 4'h0, 1'b1, 1'b0, -1, 16'h0000, 1, DIV);

    // 2: two mid-frame captures. The old frame holds and the last write shows after the wrap.
    run_slot(2'd1, 4'h0, 1'b0, LZB,   4, 16'h9999, 2, DIV);
    run_slot(2'd2, 4'h0, 1'b0, LZB,   3, 16'h1234, 2, DIV);
    run_slot(2'd3, 4'h0, 1'b0, LZB,  -1, 16'h0000, 2, DIV);
    run_slot(2'd0, 4'h4, 1'b1, 1'b0, -1, 16'h0000, 2, DIV);
    run_slot(2'd1, 4'h3, 1'b0, 1'b0, -1, 16'h0000, 2, DIV);
    run_slot(2'd2, 4'h2, 1'b0, 1'b0, -1, 16'h0000, 2, DIV);
    run_slot(2'd3, 4'h1, 1'b0, 1'b0, -1, 16'h0000, 2, DIV);

    // 3: capture on the wrap cycle itself shows in that same frame.
    run_slot(2'd0, 4'h8, 1'b1, 1'b0,  0, 16'h5678, 3, DIV);
    run_slot(2'd1, 4'h7, 1'b0, 1'b0, -1, 16'h0000, 3, DIV);
    run_slot(2'd2, 4'h6, 1'b0, 1'b0, -1, 16'h0000, 3, DIV);
    run_slot(2'd3, 4'h5, 1'b0, 1'b0, -1, 16'h0000, 3, DIV);

    // 4: disable at sel 2, capture while IDLE, then re-enable.
    run_slot(2'd0, 4'h8, 1'b1, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd1, 4'h7, 1'b0, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd2, 4'h6, 1'b0, 1'b0, -1, 16'h0000, 4, 5);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 4'h6, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b1, 16'hABCD, 2'd2, 1'b1, 4'h6, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 2'd2, 1'b1, 4'h6, 1'b0, 4);
    run_slot(2'd2, 4'h6, 1'b0, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd3, 4'h5, 1'b0, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd0, 4'hD, 1'b1, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd1, 4'hC, 1'b0, 1'b0, -1, 16'h0000, 4, DIV);
    run_slot(2'd2, 4'hB, 1'b0, 1'b0, -1, 16'h0000, 4, DIV);

    // 5: reset mid-SHOW at sel 3 with a capture pending. Display and pending must clear.
    run_slot(2'd3, 4'hA, 1'b0, 1'b0,  2, 16'h1111, 5, 6);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h0, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 4'h0, 1'b0, 5);
    run_slot(2'd0, 4'h0, 1'b0, 1'b0, -1, 16'h0000, 5, DIV);
    run_slot(2'd1, 4'h0, 1'b0, LZB,  -1, 16'h0000, 5, DIV);
    run_slot(2'd2, 4'h0, 1'b0, LZB,  -1, 16'h0000, 5, DIV);
    run_slot(2'd3, 4'h0, 1'b0, LZB,  -1, 16'h0000, 5, DIV);
    run_slot(2'd0, 4'h0, 1'b1, 1'b0, -1, 16'h0000, 5, DIV);

    // 6: frame 0070. With LZB, sel 3 and sel 2 stay dark; sel 1 and sel 0 are shown.
    run_slot(2'd1, 4'h0, 1'b0, LZB,   3, 16'h0070, 6, DIV);
    run_slot(2'd2, 4'h0, 1'b0, LZB,  -1, 16'h0000, 6, DIV);
    run_slot(2'd3, 4'h0, 1'b0, LZB,  -1, 16'h0000, 6, DIV);
    run_slot(2'd0, 4'h0, 1'b1, 1'b0, -1, 16'h0000, 6, DIV);
    run_slot(2'd1, 4'h7, 1'b0, 1'b0, -1, 16'h0000, 6, DIV);
    run_slot(2'd2, 4'h0, 1'b0, LZB,  -1, 16'h0000, 6, DIV);
    run_slot(2'd3, 4'h0, 1'b0, LZB,  -1, 16'h0000, 6, DIV);

    // Let the monitor consume the last entry, then make sure nothing is left over.
    @(posedge clk);
    #4;
    mon_on = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover got %0d queued entries, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
